// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Boot/run sequencer in front of the X9 core. It streams
//               machine-code words into instruction memory over a valid/ready
//               handshake and holds the core in reset while it does so. It then
//               releases the core, counts run cycles under a watchdog until the
//               core reports done, and signals completion to the host with a
//               req/ack handshake.
//
//               Optional build macro PROG_LOADER_CHECKSUM_EN: LOAD accepts one
//               extra trailing word. That word is an XOR checksum of the
//               program and is not written to memory. On a mismatch the block
//               sets err_chk and goes to DONE without running the core.
//
// Ports       : clk, reset       - clock, synchronous active-high reset
//               req/len/ack      - host start request, word count, completion
//               in_valid/ready/data - program word stream
//               im_wr_en/addr/dat   - instruction-memory write port
//               core_reset/core_done - core control and status
//               busy, cyc_cnt, err_timeout, err_chk - status and results
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int D       = 12,
    parameter int W       = 9,
    parameter int MAX_CYC = 4096
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic [D-1:0] len,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         im_wr_en,
    output logic [D-1:0] im_addr,
    output logic [W-1:0] im_dat,
    output logic         core_reset,
    input  logic         core_done,
    output logic         ack,
    output logic         busy,
    output logic [15:0]  cyc_cnt,
    output logic         err_timeout,
    output logic         err_chk
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [D-1:0] c_addr_one  = {{(D-1){1'b0}}, 1'b1};
    localparam logic [31:0]  c_cyc_limit = 32'(MAX_CYC - 1);
    localparam logic [15:0]  c_cyc_sat   = 16'hFFFF;

    state_t       r_state;
    state_t       w_next_state;
    logic [D-1:0] r_addr;
    logic [D-1:0] r_len;
    logic [15:0]  r_cyc_cnt;
    logic         r_err_timeout;

    logic         w_xfer;       // word accepted this cycle
    logic         w_wr;         // accepted word goes to memory
    logic         w_chk_word;   // accepted word would be the checksum
    logic         w_chk_bad;    // checksum word disagrees with running XOR
    logic         w_last_word;  // final word of the load
    logic         w_wd_hit;     // watchdog limit reached

    assign w_xfer   = (r_state == S_LOAD) && in_valid;
    assign w_wr     = w_xfer && !w_chk_word;
    // A saturated counter can never equal a limit above 16'hFFFF, so the
    // compare is made at full width.
    assign w_wd_hit = ({16'd0, r_cyc_cnt} == c_cyc_limit);

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [W-1:0] r_xor;
    logic         r_err_chk;

    // Program words occupy addresses 0..len_q-1, so the checksum arrives
    // once addr_q has reached len_q.
    assign w_chk_word  = (r_addr == r_len);
    assign w_chk_bad   = w_chk_word && (in_data != r_xor);
    assign w_last_word = w_chk_word;
    assign err_chk     = r_err_chk;
`else
    assign w_chk_word  = 1'b0;
    assign w_chk_bad   = 1'b0;
    assign w_last_word = (r_addr == (r_len - c_addr_one));
    assign err_chk     = 1'b0;
`endif

    assign cyc_cnt     = r_cyc_cnt;
    assign err_timeout = r_err_timeout;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_next_state = (len != '0) ? S_LOAD : S_RUN;
                end
            end
            S_LOAD: begin
                if (w_xfer && w_last_word) begin
                    w_next_state = w_chk_bad ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (core_done || w_wd_hit) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (!req) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from the registered state only, apart from the
    // zero-latency memory write, which follows in_valid directly.
    always_comb begin
        in_ready   = 1'b0;
        im_wr_en   = 1'b0;
        im_addr    = r_addr;
        im_dat     = '0;
        core_reset = 1'b1;
        ack        = 1'b0;
        busy       = 1'b0;
        case (r_state)
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                im_wr_en = w_wr;
                if (w_wr) begin
                    im_dat = in_data;
                end
            end
            S_RUN: begin
                core_reset = 1'b0;
                busy       = 1'b1;
            end
            S_DONE: begin
                ack = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr        <= '0;
            r_len         <= '0;
            r_cyc_cnt     <= '0;
            r_err_timeout <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_xor         <= '0;
            r_err_chk     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_len         <= len;
                        r_addr        <= '0;
                        r_cyc_cnt     <= '0;
                        r_err_timeout <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_xor         <= '0;
                        r_err_chk     <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        r_addr <= r_addr + c_addr_one;
`ifdef PROG_LOADER_CHECKSUM_EN
                        if (w_wr) begin
                            r_xor <= r_xor ^ in_data;
                        end
                        if (w_chk_bad) begin
                            r_err_chk <= 1'b1;
                        end
`endif
                    end
                end
                S_RUN: begin
                    // The count freezes on the exit edge, whether the exit is
                    // a done or a timeout. Done takes priority over timeout.
                    if (!core_done) begin
                        if (w_wd_hit) begin
                            r_err_timeout <= 1'b1;
                        end else if (r_cyc_cnt != c_cyc_sat) begin
                            r_cyc_cnt <= r_cyc_cnt + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader. A transaction-level model
//               decides what each cycle must look like: load phase, run phase
//               of known length, done/ack phase. A single compare process
//               checks every DUT output each cycle against it. Directed cases
//               pin the model with hand-computed literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;
    localparam int D       = 12;
    localparam int W       = 9;
    localparam int MAX_CYC = 16;

    logic         clk = 1'b0;
    logic         reset, req, in_valid, in_ready, im_wr_en, core_reset;
    logic         core_done, ack, busy, err_timeout, err_chk;
    logic [D-1:0] len, im_addr;
    logic [W-1:0] in_data, im_dat;
    logic [15:0]  cyc_cnt;

    always #5 clk = ~clk;

    prog_loader #(.D(D), .W(W), .MAX_CYC(MAX_CYC)) dut (
        .clk(clk), .reset(reset), .req(req), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .im_wr_en(im_wr_en), .im_addr(im_addr), .im_dat(im_dat),
        .core_reset(core_reset), .core_done(core_done), .ack(ack),
        .busy(busy), .cyc_cnt(cyc_cnt), .err_timeout(err_timeout),
        .err_chk(err_chk)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Per-cycle expectations written by the stimulus, read by the compare process
    bit           e_en = 1'b0;
    bit           e_zero = 1'b0;
    logic         e_in_ready, e_wr, e_core_reset, e_ack, e_busy, e_to, e_chk;
    logic [D-1:0] e_addr;
    logic [W-1:0] e_dat;
    logic [15:0]  e_cyc;

    // Result registers of the last operation as the model sees them
    logic [15:0]  m_cyc = '0;
    logic         m_to  = 1'b0;
    logic         m_chk = 1'b0;

    // Observed memory writes
    logic [D-1:0] cap_addr[$];
    logic [W-1:0] cap_dat[$];

    // Directed stimulus overrides
    logic [W-1:0] dw[$];
    bit           dchk_en = 1'b0;
    logic [W-1:0] dchk = '0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (e_en) begin
            cmp("in_ready",    32'(in_ready),    32'(e_in_ready));
            cmp("im_wr_en",    32'(im_wr_en),    32'(e_wr));
            cmp("core_reset",  32'(core_reset),  32'(e_core_reset));
            cmp("ack",         32'(ack),         32'(e_ack));
            cmp("busy",        32'(busy),        32'(e_busy));
            cmp("cyc_cnt",     32'(cyc_cnt),     32'(e_cyc));
            cmp("err_timeout", 32'(err_timeout), 32'(e_to));
            cmp("err_chk",     32'(err_chk),     32'(e_chk));
            if (e_wr || e_zero) begin
                cmp("im_addr", 32'(im_addr), 32'(e_addr));
                cmp("im_dat",  32'(im_dat),  32'(e_dat));
            end
            if (im_wr_en === 1'b1) begin
                cap_addr.push_back(im_addr);
                cap_dat.push_back(im_dat);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_set(input logic rdy, input logic wr, input logic cr, input logic a,
                           input logic b, input logic [15:0] c, input logic to, input logic ch);
        e_in_ready = rdy; e_wr = wr; e_core_reset = cr; e_ack = a; e_busy = b;
        e_cyc = c; e_to = to; e_chk = ch;
    endtask

    // IDLE or post-reset: core held, results unchanged
    task automatic exp_rest();
        exp_set(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, m_cyc, m_to, m_chk);
    endtask

    // One full host operation. n_done is the 1-based RUN cycle on which core_done
    // is raised; 0 or anything above MAX_CYC means the core never finishes.
    // gap < 0 gives random stalls, otherwise exactly gap idle cycles between words.
    task automatic run_txn(input int L, input int n_done, input int gap, input bit bad,
                           input bit lit, input int lit_cyc, input bit lit_to, input bit lit_chk);
        logic [W-1:0] words[$];
        logic [W-1:0] x, cw;
        int  total, k, gleft, run_n, hold;
        bit  v, chk_fail, finishes;
        words = {};
        if (dw.size() != 0) words = dw;
        else for (int i = 0; i < L; i++) words.push_back(W'($urandom));
        x = '0;
        foreach (words[i]) x ^= words[i];
        cw = dchk_en ? dchk : (bad ? (x ^ W'($urandom_range(1, 511))) : x);

        // IDLE cycle carrying the request
        req = 1'b1; len = D'(L);
        in_valid = 1'($urandom); in_data = W'($urandom); core_done = 1'($urandom);
        exp_rest();
        step();
        m_cyc = '0; m_to = 1'b0; m_chk = 1'b0;
        chk_fail = 1'b0;

        if (L > 0) begin
            total = L;
`ifdef PROG_LOADER_CHECKSUM_EN
            total = L + 1;
            chk_fail = (cw != x);
`endif
            k = 0; gleft = 0;
            while (k < total) begin
                v = (gap >= 0) ? (gleft == 0) : (($urandom % 3) != 0);
                in_valid = v;
                in_data  = v ? ((k < L) ? words[k] : cw) : W'($urandom);
                req = 1'($urandom); core_done = 1'($urandom);
                exp_set(1'b1, v && (k < L), 1'b1, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0);
                e_addr = D'(k); e_dat = in_data;
                step();
                if (v) begin
                    k++;
                    gleft = (gap >= 0) ? gap : 0;
                end else begin
                    gleft--;
                end
            end
        end
        in_valid = 1'b0; req = 1'b1;

        if (!chk_fail) begin
            finishes = (n_done >= 1) && (n_done <= MAX_CYC);
            run_n = finishes ? n_done : MAX_CYC;
            for (int r = 1; r <= run_n; r++) begin
                core_done = (r == n_done);
                in_valid = 1'($urandom); in_data = W'($urandom);
                exp_set(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'(r - 1), 1'b0, 1'b0);
                step();
            end
            m_cyc = 16'(run_n - 1);
            m_to  = !finishes;
        end else begin
            m_chk = 1'b1;
        end

        // DONE: hold req a few cycles, then drop it; ack stays up through that cycle
        hold = $urandom_range(0, 2);
        for (int h = 0; h <= hold; h++) begin
            req = (h != hold);
            core_done = 1'($urandom); in_valid = 1'($urandom); in_data = W'($urandom);
            exp_set(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, m_cyc, m_to, m_chk);
            if (h == 0 && lit) begin
                @(negedge clk); #1;
                cmp("lit_cyc_cnt",     32'(cyc_cnt),     32'(lit_cyc));
                cmp("lit_err_timeout", 32'(err_timeout), 32'(lit_to));
                cmp("lit_err_chk",     32'(err_chk),     32'(lit_chk));
            end
            step();
        end
        req = 1'b0; core_done = 1'b0;
        exp_rest();
        step();
        dw = {}; dchk_en = 1'b0;
    endtask

    task automatic check_caps(input logic [W-1:0] ld [3]);
        cmp("cap_count", 32'(cap_addr.size()), 32'd3);
        for (int i = 0; i < 3 && i < cap_addr.size(); i++) begin
            cmp("cap_addr", 32'(cap_addr[i]), 32'(i));
            cmp("cap_dat",  32'(cap_dat[i]),  32'(ld[i]));
        end
    endtask

    initial begin
        logic [W-1:0] lw [3];
        lw = '{9'h1A3, 9'h005, 9'h1FF};
        reset = 1'b1; req = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; core_done = 1'b0;

        // Reset held for two edges
        step();
        e_en = 1'b1; e_zero = 1'b1; e_addr = '0; e_dat = '0;
        exp_rest();
        in_data = 9'h155; in_valid = 1'b1;
        step();
        reset = 1'b0; e_zero = 1'b0; in_valid = 1'b0;
        exp_rest();
        step();

        // Back-to-back load, done on the 10th RUN cycle
        cap_addr = {}; cap_dat = {};
        dw = {9'h1A3, 9'h005, 9'h1FF};
        run_txn(3, 10, 0, 1'b0, 1'b1, 9, 1'b0, 1'b0);
        check_caps(lw);

        // Same load with 4-cycle gaps between words
        cap_addr = {}; cap_dat = {};
        dw = {9'h1A3, 9'h005, 9'h1FF};
        run_txn(3, 5, 4, 1'b0, 1'b1, 4, 1'b0, 1'b0);
        check_caps(lw);

        // Watchdog expiry, and done on the very last cycle
        run_txn(2, 0, 0, 1'b0, 1'b1, 15, 1'b1, 1'b0);
        run_txn(1, 16, 0, 1'b0, 1'b1, 15, 1'b0, 1'b0);

        // len=0 re-runs the resident program
        run_txn(0, 3, 0, 1'b0, 1'b1, 2, 1'b0, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
        cap_addr = {}; cap_dat = {};
        dw = {9'h003, 9'h005}; dchk_en = 1'b1; dchk = 9'h006;
        run_txn(2, 5, 0, 1'b0, 1'b1, 4, 1'b0, 1'b0);
        cmp("chk_ok_writes", 32'(cap_addr.size()), 32'd2);
        cap_addr = {}; cap_dat = {};
        dw = {9'h003, 9'h005}; dchk_en = 1'b1; dchk = 9'h007;
        run_txn(2, 5, 0, 1'b0, 1'b1, 0, 1'b0, 1'b1);
        cmp("chk_bad_writes", 32'(cap_addr.size()), 32'd2);
`endif

        // Reset in the middle of a load aborts it
        req = 1'b1; len = D'(5); exp_rest(); step();
        m_cyc = '0; m_to = 1'b0; m_chk = 1'b0;
        in_valid = 1'b1; in_data = 9'h0AA;
        exp_set(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0);
        e_addr = D'(0); e_dat = in_data; step();
        in_data = 9'h0BB; reset = 1'b1;
        e_addr = D'(1); e_dat = in_data; step();
        req = 1'b0; e_zero = 1'b1; e_addr = '0; e_dat = '0;
        exp_rest(); step();
        reset = 1'b0; in_valid = 1'b0; e_zero = 1'b0;
        exp_rest(); step();

        // Randomized operations
        for (int t = 0; t < 40; t++) begin
            run_txn($urandom_range(0, 8), $urandom_range(0, 20), -1,
                    1'(($urandom % 3) == 0), 1'b0, 0, 1'b0, 1'b0);
            for (int i = 0; i < $urandom_range(0, 2); i++) begin
                in_valid = 1'($urandom); core_done = 1'($urandom);
                exp_rest(); step();
            end
        end

        e_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
